// File: rtl/psram_burst_rd.sv
// psram_burst_rd -- synchronous-burst PSRAM read sequencer.
//
// Presents the address with ADV# low for one cycle, waits a fixed initial latency, then
// captures one DQ word on every clock edge at which the IOB-registered WAIT is low.
// Captured words stream out on rd_valid/rd_data, and rd_last marks the final word. The
// sequencer also drives wait_en, the synchronous set of the WAIT IOB flop. This keeps
// wait_q at 1 whenever no burst is streaming.
//
// Ports
//   i_clk, i_rst       clock; synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_addr, i_req_len
//                      burst request (len = words-1); ready only in IDLE
//   i_wait_q, i_dq_q   IOB-registered WAIT and DQ, aligned with each other
//   o_wait_en          sync set of the WAIT IOB flop (1 forces wait_q=1 next edge)
//   o_psram_ce_n/adv_n/oe_n/addr
//                      PSRAM pad controls, all registered
//   o_rd_valid/o_rd_data/o_rd_last
//                      captured word stream
//   o_err_timeout      one-cycle pulse when a burst is aborted on WAIT timeout
`timescale 1ns/1ps
module psram_burst_rd #(
   parameter int unsigned ADDR_W  = 23,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned LEN_W   = 6,
   parameter int unsigned LATENCY = 4,
   parameter int unsigned TMO_CYC = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [LEN_W-1:0]  i_req_len,
   input  logic              i_wait_q,
   output logic              o_wait_en,
   input  logic [DATA_W-1:0] i_dq_q,
   output logic              o_psram_ce_n,
   output logic              o_psram_adv_n,
   output logic              o_psram_oe_n,
   output logic [ADDR_W-1:0] o_psram_addr,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_rd_last,
   output logic              o_err_timeout
);

   localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC > 0) ? (TMO_CYC - 1) : 0);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_LAT   = 3'd2;
   localparam logic [2:0] S_BURST = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        r_state,    w_state_nxt;
   logic [LEN_W-1:0]  r_len,      w_len_nxt;
   logic [LAT_W-1:0]  r_lat_cnt,  w_lat_nxt;
   logic [LEN_W:0]    r_word_cnt, w_word_nxt;
   logic [TMO_W-1:0]  r_tmo_cnt,  w_tmo_nxt;
   logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
   logic [DATA_W-1:0] r_rd_data,  w_rd_data_nxt;
   logic              r_rd_valid, w_rd_valid_nxt;
   logic              r_rd_last,  w_rd_last_nxt;
   logic              r_err,      w_err_nxt;
   logic              r_req_ready, r_wait_en, r_ce_n, r_adv_n, r_oe_n;
   logic              w_streaming;

   always_comb begin
      w_state_nxt    = r_state;
      w_len_nxt      = r_len;
      w_lat_nxt      = r_lat_cnt;
      w_word_nxt     = r_word_cnt;
      w_tmo_nxt      = r_tmo_cnt;
      w_addr_nxt     = r_addr;
      w_rd_data_nxt  = r_rd_data;
      w_rd_valid_nxt = 1'b0;
      w_rd_last_nxt  = 1'b0;
      w_err_nxt      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_req_valid && r_req_ready) begin
               w_state_nxt = S_ADDR;
               w_len_nxt   = i_req_len;
               w_addr_nxt  = i_req_addr;
            end
         end
         S_ADDR: begin
            w_state_nxt = S_LAT;
            w_lat_nxt   = '0;
         end
         S_LAT: begin
            // wait_q is not trusted here: the IOB set only releases one edge into LAT.
            if (r_lat_cnt == LAT_LAST) begin
               w_state_nxt = S_BURST;
               w_word_nxt  = '0;
               w_tmo_nxt   = '0;
            end else begin
               w_lat_nxt = r_lat_cnt + 1'b1;
            end
         end
         S_BURST: begin
            if (!i_wait_q) begin
               w_rd_valid_nxt = 1'b1;
               w_rd_data_nxt  = i_dq_q;
               w_tmo_nxt      = '0;
               if (r_word_cnt == {1'b0, r_len}) begin
                  w_rd_last_nxt = 1'b1;
                  w_state_nxt   = S_DONE;
               end else begin
                  w_word_nxt = r_word_cnt + 1'b1;
               end
            end else if ((TMO_CYC != 0) && (r_tmo_cnt == TMO_LAST)) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               // With no timeout configured the counter simply wraps unobserved.
               w_tmo_nxt = r_tmo_cnt + 1'b1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pad controls are registered from the next state so they line up with the state.
   assign w_streaming = (w_state_nxt == S_LAT) || (w_state_nxt == S_BURST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_lat_cnt   <= '0;
         r_word_cnt  <= '0;
         r_tmo_cnt   <= '0;
         r_addr      <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
         r_err       <= 1'b0;
         r_req_ready <= 1'b0;
         r_wait_en   <= 1'b1;
         r_ce_n      <= 1'b1;
         r_adv_n     <= 1'b1;
         r_oe_n      <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_len       <= w_len_nxt;
         r_lat_cnt   <= w_lat_nxt;
         r_word_cnt  <= w_word_nxt;
         r_tmo_cnt   <= w_tmo_nxt;
         r_addr      <= w_addr_nxt;
         r_rd_data   <= w_rd_data_nxt;
         r_rd_valid  <= w_rd_valid_nxt;
         r_rd_last   <= w_rd_last_nxt;
         r_err       <= w_err_nxt;
         r_req_ready <= (w_state_nxt == S_IDLE);
         r_wait_en   <= !w_streaming;
         r_ce_n      <= !(w_streaming || (w_state_nxt == S_ADDR));
         r_adv_n     <= (w_state_nxt != S_ADDR);
         r_oe_n      <= !w_streaming;
      end
   end

   assign o_req_ready   = r_req_ready;
   assign o_wait_en     = r_wait_en;
   assign o_psram_ce_n  = r_ce_n;
   assign o_psram_adv_n = r_adv_n;
   assign o_psram_oe_n  = r_oe_n;
   assign o_psram_addr  = r_addr;
   assign o_rd_valid    = r_rd_valid;
   assign o_rd_data     = r_rd_data;
   assign o_rd_last     = r_rd_last;
   assign o_err_timeout = r_err;

endmodule

// File: tb/tb_psram_burst_rd.sv
// Bench for psram_burst_rd.
//
// The reference model works from edge arithmetic. Edge 0 is the accept edge, and the
// LAT phase covers edges 1..LATENCY. Words are sampled at edges LATENCY+2 and later,
// at every edge where wait_q is low. The model stops on len+1 words or on TMO_CYC
// consecutive stalls, then expects one DONE cycle followed by IDLE.
`timescale 1ns/1ps
module tb_psram_burst_rd;
   localparam int unsigned ADDR_W  = 23;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned LEN_W   = 6;
   localparam int unsigned LATENCY = 4;
   localparam int unsigned TMO_CYC = 64;

   // Control vector order: ready, wait_en, ce_n, adv_n, oe_n, rd_valid, rd_last, err.
   localparam logic [7:0] C_RST   = 8'b0111_1000;
   localparam logic [7:0] C_IDLE  = 8'b1111_1000;
   localparam logic [7:0] C_ADDR  = 8'b0100_1000;
   localparam logic [7:0] C_RUN   = 8'b0001_0000;
   localparam logic [7:0] C_DONE  = 8'b0111_1000;

   logic              clk = 1'b0;
   logic              i_rst;
   logic              i_req_valid;
   logic              o_req_ready;
   logic [ADDR_W-1:0] i_req_addr;
   logic [LEN_W-1:0]  i_req_len;
   logic              i_wait_q;
   logic              o_wait_en;
   logic [DATA_W-1:0] i_dq_q;
   logic              o_psram_ce_n;
   logic              o_psram_adv_n;
   logic              o_psram_oe_n;
   logic [ADDR_W-1:0] o_psram_addr;
   logic              o_rd_valid;
   logic [DATA_W-1:0] o_rd_data;
   logic              o_rd_last;
   logic              o_err_timeout;

   int checks = 0;
   int errors = 0;

   psram_burst_rd #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .LEN_W   (LEN_W),
      .LATENCY (LATENCY),
      .TMO_CYC (TMO_CYC)
   ) u_dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_req_addr    (i_req_addr),
      .i_req_len     (i_req_len),
      .i_wait_q      (i_wait_q),
      .o_wait_en     (o_wait_en),
      .i_dq_q        (i_dq_q),
      .o_psram_ce_n  (o_psram_ce_n),
      .o_psram_adv_n (o_psram_adv_n),
      .o_psram_oe_n  (o_psram_oe_n),
      .o_psram_addr  (o_psram_addr),
      .o_rd_valid    (o_rd_valid),
      .o_rd_data     (o_rd_data),
      .o_rd_last     (o_rd_last),
      .o_err_timeout (o_err_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] act_ctl();
      return {o_req_ready, o_wait_en, o_psram_ce_n, o_psram_adv_n, o_psram_oe_n,
              o_rd_valid, o_rd_last, o_err_timeout};
   endfunction

   // Wait modes: 0 never stall, 1 random stalls, 2 two stalls after word 2,
   // 3 stall forever after word 1. rst_at < 0 means no reset is applied.
   task automatic run_burst(input string name, input logic [ADDR_W-1:0] addr,
                            input logic [LEN_W-1:0] len, input int mode, input bit hold,
                            input int rst_at);
      int words = 0;
      int consec = 0;
      int gap = 0;
      int budget;
      bit done = 1'b0;
      logic w_s;
      logic [DATA_W-1:0] d_s;
      logic [DATA_W-1:0] ed;
      logic [7:0] e;
      logic v, l, er;
      budget = int'(LATENCY) + 8 * (int'(len) + 2) + int'(TMO_CYC) + 16;
      i_req_valid = 1'b1;
      i_req_addr  = addr;
      i_req_len   = len;
      i_wait_q    = 1'b1;
      i_dq_q      = DATA_W'($urandom);
      for (int k = 0; k < budget; k++) begin
         w_s = i_wait_q;
         d_s = i_dq_q;
         @(posedge clk); #1;
         if (k == rst_at) begin
            checks++;
            if (act_ctl() !== C_RST || o_rd_data !== '0 || o_psram_addr !== '0) begin
               errors++;
               $display("FAIL %s rst_mid ctl=%b exp %b data=%h addr=%h exp 0", name,
                        act_ctl(), C_RST, o_rd_data, o_psram_addr);
            end
            @(negedge clk);
            i_rst = 1'b0; i_req_valid = 1'b0; i_wait_q = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (act_ctl() !== C_IDLE) begin
               errors++;
               $display("FAIL %s rst_release ctl=%b exp %b", name, act_ctl(), C_IDLE);
            end
            @(negedge clk);
            return;
         end
         if (done) begin
            checks++;
            if (act_ctl() !== C_IDLE) begin
               errors++;
               $display("FAIL %s idle_after_done ctl=%b exp %b", name, act_ctl(), C_IDLE);
            end
            @(negedge clk);
            return;
         end
         v = 1'b0; l = 1'b0; er = 1'b0; ed = '0;
         if (k >= int'(LATENCY) + 2) begin
            if (!w_s) begin
               words++;
               consec = 0;
               v = 1'b1;
               ed = d_s;
               if (words == int'(len) + 1) begin
                  l = 1'b1;
                  done = 1'b1;
               end
            end else begin
               consec++;
               if (TMO_CYC != 0 && consec == int'(TMO_CYC)) begin
                  er = 1'b1;
                  done = 1'b1;
               end
            end
         end
         if (k == 0) e = C_ADDR;
         else if (done) e = C_DONE | {5'b0, v, l, er};
         else e = C_RUN | {5'b0, v, 2'b00};
         checks++;
         if (act_ctl() !== e || (v && o_rd_data !== ed) || (k == 0 && o_psram_addr !== addr))
         begin
            errors++;
            $display("FAIL %s edge=%0d ctl=%b exp %b data=%h exp %h addr=%h exp %h", name, k,
                     act_ctl(), e, o_rd_data, ed, o_psram_addr, addr);
         end
         @(negedge clk);
         i_req_valid = hold;
         i_req_addr  = ADDR_W'($urandom);
         i_req_len   = LEN_W'($urandom);
         i_dq_q      = DATA_W'($urandom);
         i_rst       = (k + 1 == rst_at);
         if (done) i_wait_q = 1'b1;
         else if (k + 1 <= int'(LATENCY) + 1) i_wait_q = 1'($urandom);
         else begin
            case (mode)
               1: i_wait_q = ($urandom_range(0, 3) == 0);
               2: begin
                  i_wait_q = (words == 2 && gap < 2);
                  if (i_wait_q) gap++;
               end
               3: i_wait_q = (words >= 1);
               default: i_wait_q = 1'b0;
            endcase
         end
      end
      checks++;
      errors++;
      $display("FAIL %s cycle_budget expired words=%0d exp %0d", name, words, int'(len) + 1);
      i_req_valid = 1'b0;
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (act_ctl() !== C_RST || o_rd_data !== '0 || o_psram_addr !== '0) begin
         errors++;
         $display("FAIL reset ctl=%b exp %b data=%h addr=%h exp 0", act_ctl(), C_RST,
                  o_rd_data, o_psram_addr);
      end
      @(negedge clk);
      i_rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (act_ctl() !== C_IDLE) begin
         errors++;
         $display("FAIL reset_release ctl=%b exp %b", act_ctl(), C_IDLE);
      end
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_burst("basic", 23'h1234, 6'd3, 0, 1'b0, -1);
   endtask

   task automatic test_wait_gap();
      run_burst("wait_gap", ADDR_W'($urandom), 6'd3, 2, 1'b0, -1);
   endtask

   task automatic test_timeout();
      run_burst("timeout", ADDR_W'($urandom), 6'd10, 3, 1'b0, -1);
   endtask

   task automatic test_len_edges();
      run_burst("len0", ADDR_W'($urandom), 6'd0, 1, 1'b0, -1);
      run_burst("len63", ADDR_W'($urandom), 6'd63, 1, 1'b0, -1);
   endtask

   task automatic test_rst_mid();
      run_burst("rst_mid", ADDR_W'($urandom), 6'd7, 0, 1'b0, int'(LATENCY) + 4);
      run_burst("after_rst", ADDR_W'($urandom), 6'd2, 0, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         run_burst("b2b", ADDR_W'($urandom), LEN_W'($urandom_range(0, 5)), 1, 1'b1, -1);
      end
      i_req_valid = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         run_burst("random", ADDR_W'($urandom), LEN_W'($urandom), 1, 1'b0, -1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      i_rst       = 1'b1;
      i_req_valid = 1'b0;
      i_req_addr  = '0;
      i_req_len   = '0;
      i_wait_q    = 1'b1;
      i_dq_q      = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_wait_gap();
      test_timeout();
      test_len_edges();
      test_rst_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
